// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit hysteresis counters
// Lookup is combinational from registered state; updates commit at the following clock edge.
module branch_target_buffer #(
  parameter int PC_WIDTH    = 32,
  parameter int ENTRY_NUM   = 64,
  parameter int USE_COUNTER = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                btbHit,
  output logic [PC_WIDTH-1:0] btbPredictedPc,
  input  logic                updEn,
  input  logic [PC_WIDTH-1:0] updPc,
  input  logic                updTaken,
  input  logic [PC_WIDTH-1:0] updTarget,
  input  logic                flush
);

  localparam int IDX   = $clog2(ENTRY_NUM);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q    [ENTRY_NUM];
  logic [PC_WIDTH-1:0]  target_q [ENTRY_NUM];
  logic [1:0]           cnt_q    [ENTRY_NUM];

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             cnt_ok;
  logic             upd_hit, upd_go, alloc, cnt_we, tgt_we;
  logic [1:0]       cnt_d;

  assign lk_idx  = pc[IDX+1:2];
  assign lk_tag  = pc[PC_WIDTH-1:IDX+2];
  assign upd_idx = updPc[IDX+1:2];
  assign upd_tag = updPc[PC_WIDTH-1:IDX+2];

  // Counter state is always maintained; it only qualifies the hit when enabled.
  assign cnt_ok = (USE_COUNTER == 0) || cnt_q[lk_idx][1];
  assign btbHit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && cnt_ok;
  assign btbPredictedPc = btbHit ? target_q[lk_idx] : (pc + PC_WIDTH'(4));

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_go  = updEn && !flush;
  assign alloc   = upd_go && updTaken && !upd_hit;
  assign cnt_we  = upd_go && (upd_hit || updTaken);
  assign tgt_we  = upd_go && updTaken;

  always_comb begin
    cnt_d = cnt_q[upd_idx];
    if (!upd_hit) begin
      cnt_d = 2'd2;
    end else if (updTaken) begin
      if (cnt_q[upd_idx] != 2'd3) cnt_d = cnt_q[upd_idx] + 2'd1;
    end else begin
      if (cnt_q[upd_idx] != 2'd0) cnt_d = cnt_q[upd_idx] - 2'd1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (alloc) begin
      valid_d[upd_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) cnt_q[i] <= 2'd0;
    end else begin
      valid_q <= valid_d;
      if (cnt_we) cnt_q[upd_idx] <= cnt_d;
    end
  end

  // Tags and targets carry no reset; they are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (rst && tgt_we) target_q[upd_idx] <= updTarget;
    if (rst && alloc)  tag_q[upd_idx]    <= upd_tag;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - randomized and directed bench for branch_target_buffer
module tb_branch_target_buffer;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        updEn, updTaken, flush;
  logic [31:0] updPc, updTarget;
  logic        hit1, hit0;
  logic [31:0] ppc1, ppc0;

  int checks = 0;
  int errors = 0;

  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_cnt   [N];

  always #5 clk = ~clk;

  branch_target_buffer #(.PC_WIDTH(32), .ENTRY_NUM(N), .USE_COUNTER(1)) dut1 (
    .clk(clk), .rst(rst), .pc(pc), .btbHit(hit1), .btbPredictedPc(ppc1),
    .updEn(updEn), .updPc(updPc), .updTaken(updTaken), .updTarget(updTarget), .flush(flush));

  branch_target_buffer #(.PC_WIDTH(32), .ENTRY_NUM(N), .USE_COUNTER(0)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .btbHit(hit0), .btbPredictedPc(ppc0),
    .updEn(updEn), .updPc(updPc), .updTaken(updTaken), .updTarget(updTarget), .flush(flush));

  function automatic int idx_of(logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] a);
    return a / (4 * N);
  endfunction

  function automatic bit m_hit(int uc, logic [31:0] a);
    int i = idx_of(a);
    return m_valid[i] && (m_tag[i] == tag_of(a)) && (uc == 0 || m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ppc(int uc, logic [31:0] a);
    return m_hit(uc, a) ? m_tgt[idx_of(a)] : a + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic model_edge();
    int  i;
    bit  h;
    if (!rst) return;
    if (flush) begin
      for (int k = 0; k < N; k++) m_valid[k] = 0;
      return;
    end
    if (!updEn) return;
    i = idx_of(updPc);
    h = m_valid[i] && (m_tag[i] == tag_of(updPc));
    if (h && updTaken) begin
      m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      m_tgt[i] = updTarget;
    end else if (h) begin
      m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end else if (updTaken) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(updPc);
      m_tgt[i]   = updTarget;
      m_cnt[i]   = 2;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_hit1"}, {31'd0, hit1}, {31'd0, m_hit(1, pc)});
    chk({tag, "_ppc1"}, ppc1, m_ppc(1, pc));
    chk({tag, "_hit0"}, {31'd0, hit0}, {31'd0, m_hit(0, pc)});
    chk({tag, "_ppc0"}, ppc0, m_ppc(0, pc));
  endtask

  // Inputs are set just after a rising edge; outputs are checked mid-cycle, then the edge commits.
  task automatic step(string tag);
    #4;
    chk_model(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic upd(logic [31:0] a, bit taken, logic [31:0] tgt);
    updEn = 1'b1; updPc = a; updTaken = taken; updTarget = tgt;
  endtask

  task automatic idle();
    updEn = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pc = 32'h100; flush = 1'b0;
    upd(32'h100, 1'b1, 32'h200);
    model_reset();
    #1;
    chk("rst_hit", {31'd0, hit1}, 32'd0);
    chk("rst_ppc", ppc1, 32'h104);
    @(posedge clk); #1;
    step("rst_upd_dropped");
    rst = 1'b1; idle();
    step("cold");
    chk("cold_ppc", ppc1, 32'h104);

    upd(32'h100, 1'b1, 32'h200);
    #4;
    chk("same_cycle_hit", {31'd0, hit1}, 32'd0);
    #0 step("alloc_cycle");
    idle();
    #4;
    chk("alloc_hit", {31'd0, hit1}, 32'd1);
    chk("alloc_ppc", ppc1, 32'h200);
    #0 step("alloc_next");

    upd(32'h100, 1'b0, 32'h0);
    step("nt1");
    idle();
    #4;
    chk("hyst_hit_uc1", {31'd0, hit1}, 32'd0);
    chk("hyst_hit_uc0", {31'd0, hit0}, 32'd1);
    #0 step("nt1_look");
    for (int k = 0; k < 3; k++) begin
      upd(32'h100, 1'b1, 32'h200);
      step("taken_n");
    end
    for (int k = 0; k < 2; k++) begin
      upd(32'h100, 1'b0, 32'h0);
      step("nt_n");
    end
    idle();
    #4;
    chk("sat3_then_2nt_uc1", {31'd0, hit1}, 32'd0);
    #0 step("sat_look");

    upd(32'h100, 1'b1, 32'h200);
    step("re_arm");
    upd(32'h200, 1'b1, 32'h400);
    step("alias_alloc");
    upd(32'h300, 1'b0, 32'h0);
    pc = 32'h100;
    step("alias_old");
    idle();
    chk("alias_old_hit", {31'd0, hit1}, 32'd0);
    pc = 32'h200;
    #4;
    chk("alias_new_hit", {31'd0, hit1}, 32'd1);
    chk("alias_new_ppc", ppc1, 32'h400);
    #0 step("alias_new");

    flush = 1'b1;
    upd(32'h500, 1'b1, 32'h600);
    step("flush_cycle");
    idle();
    pc = 32'h200;
    #4;
    chk("flush_miss_old", {31'd0, hit0}, 32'd0);
    #0 step("flush_old");
    pc = 32'h500;
    #4;
    chk("flush_no_alloc", {31'd0, hit0}, 32'd0);
    #0 step("flush_new");

    pc = 32'hFFFF_FFFC;
    #4;
    chk("wrap_ppc", ppc1, 32'h0);
    #0 step("wrap");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      updEn     = ($urandom_range(0, 3) != 0);
      updPc     = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2);
      updTaken  = ($urandom_range(0, 2) != 0);
      updTarget = $urandom & 32'hFFFF_FFFC;
      flush     = ($urandom_range(0, 49) == 0);
      pc        = ($urandom_range(0, 1) != 0) ? a : updPc;
      step("rand");
    end

    idle();
    upd(32'h100, 1'b1, 32'h240);
    step("pre_async");
    idle();
    pc = 32'h100;
    #1;
    chk("pre_async_hit", {31'd0, hit0}, 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_hit1", {31'd0, hit1}, 32'd0);
    chk("async_hit0", {31'd0, hit0}, 32'd0);
    chk("async_ppc", ppc0, 32'h104);
    @(posedge clk); #1;
    rst = 1'b1;
    step("after_async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, fetch/branch address width in bits.
REQ-002 SHALL have parameter ENTRY_NUM, default 64, number of direct-mapped entries; power of two, 4..1024.
REQ-003 SHALL have parameter USE_COUNTER, default 1; 1 = 2-bit saturating-counter qualified hit, 0 = hit on valid+tag only.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc  input  PC_WIDTH  fetch-stage lookup address.
REQ-007 SHALL have port btbHit  output  1  prediction taken for pc.
REQ-008 SHALL have port btbPredictedPc  output  PC_WIDTH  next fetch address.
REQ-009 SHALL have port updEn  input  1  resolved-branch update valid, from execute stage.
REQ-010 SHALL have port updPc  input  PC_WIDTH  address of the resolved branch.
REQ-011 SHALL have port updTaken  input  1  resolved direction.
REQ-012 SHALL have port updTarget  input  PC_WIDTH  resolved target address.
REQ-013 SHALL have port flush  input  1  invalidate all entries.

Function
REQ-014 SHALL derive IDX = log2(ENTRY_NUM); index = addr[IDX+1:2]; tag = addr[PC_WIDTH-1:IDX+2]; addr[1:0] ignored.
REQ-015 SHALL store per entry: valid (1), tag, target (PC_WIDTH), counter (2).
REQ-016 SHALL perform lookup combinationally from registered state: btbHit = valid & tag match & (counter>=2 when USE_COUNTER=1).
REQ-017 SHALL drive btbPredictedPc = stored target when btbHit=1, else pc+4, truncated modulo 2^PC_WIDTH (wrap, no carry out).
REQ-018 SHALL apply updates at the rising clk edge after updEn=1; lookup in the same cycle returns pre-update contents (no bypass).
REQ-019 SHALL, on update hit (valid & tag match) with updTaken=1, increment counter saturating at 3 and overwrite target with updTarget.
REQ-020 SHALL, on update hit with updTaken=0, decrement counter saturating at 0; target and valid unchanged.
REQ-021 SHALL, on update miss with updTaken=1, allocate: valid=1, tag, target=updTarget, counter=2, replacing any previous occupant.
REQ-022 SHALL, on update miss with updTaken=0, leave the entry unchanged.
REQ-023 SHALL update counters identically when USE_COUNTER=0 (state kept, ignored for hit).
REQ-024 SHALL, on flush=1, clear every valid bit at the next edge; tags, targets, counters unchanged.
REQ-025 SHALL give flush priority over a simultaneous updEn; that update is dropped.
REQ-026 SHALL treat updEn with X-free addresses only; behaviour for updEn=0 is no state change.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all valid bits and set all counters to 0.
REQ-028 SHALL, during and after reset until first allocation, output btbHit=0 and btbPredictedPc=pc+4.
REQ-029 SHALL discard any update coincident with reset assertion; reset mid-operation loses all entries.

Verification
REQ-030 SHALL cover cold lookup: reset, pc=0x100 -> btbHit=0, btbPredictedPc=0x104.
REQ-031 SHALL cover allocate/hit: update updPc=0x100, taken, target 0x200; next cycle pc=0x100 -> btbHit=1, btbPredictedPc=0x200; same cycle as update -> btbHit=0.
REQ-032 SHALL cover hysteresis: from counter=2, one not-taken update -> counter 1, btbHit=0 (USE_COUNTER=1) and btbHit=1 (USE_COUNTER=0); two taken -> counter 3, third taken stays 3.
REQ-033 SHALL cover aliasing: ENTRY_NUM=64, allocate 0x100 then taken update 0x200 (same index, different tag) -> pc=0x100 misses, pc=0x200 hits; not-taken miss on 0x300 leaves 0x200 entry intact.
REQ-034 SHALL cover flush priority: flush=1 with updEn=1 same cycle -> all lookups miss next cycle, no allocation.
REQ-035 SHALL cover wrap: PC_WIDTH=32, pc=0xFFFFFFFC miss -> btbPredictedPc=0x00000000; async rst=0 mid-run -> btbHit=0 immediately, without a clock edge.
